mantissa_addsub_pipe: RTL
=========================

Name: mantissa_addsub_pipe

Overview:
- Pipelined, parametrised successor to the combinational mantissa add/sub stage of the FP adder/subtractor.
- Takes two sign-magnitude mantissas with explicit hidden bits and an add/sub opcode, and produces the result sign, magnitude, carry-out and zero flag.
- Two register stages with a valid/ready handshake on both sides.
- Sits between the exponent-align stage, which supplies shifted mantissas, and the normalise/round stage, which consumes carry and magnitude.

Parameters:
- MANT_W, 23, stored fraction width; the datapath magnitude is MANT_W+1 bits including the hidden bit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline clear.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts the operand set this cycle.
- sign_a  input  1  sign of operand A.
- hid_a  input  1  hidden bit of A: 1 if normal/unshifted, 0 if denormal or shifted out.
- frac_a  input  MANT_W  fraction of A.
- sign_b  input  1  sign of operand B.
- hid_b  input  1  hidden bit of B.
- frac_b  input  MANT_W  fraction of B.
- op  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- res_sign  output  1  result sign.
- res_carry  output  1  carry out of the magnitude add; always 0 for effective subtraction.
- res_mag  output  MANT_W+1  result magnitude.
- res_zero  output  1  res_mag==0 and res_carry==0.

Behaviour:
- Reset (rst_n low, async): s1_valid=0, out_valid=0, res_sign=0, res_carry=0, res_mag=0, res_zero=0. While in reset, in_ready=0.
- Operand forms: MA={hid_a,frac_a}, MB={hid_b,frac_b}, eff_sub = sign_a ^ sign_b ^ op, sb_eff = sign_b ^ op.
- Stage 1 (capture on input handshake): register eff_sub, a_ge_b = (MA>=MB), the larger magnitude as BIG, the smaller as SML, sign_a and sb_eff.
- Stage 2 arithmetic, effective add:
  - {res_carry,res_mag} = BIG+SML, computed MANT_W+2 bits wide.
  - res_sign = sign_a, except when both magnitudes are 0: res_sign = sign_a & sb_eff.
- Stage 2 arithmetic, effective sub:
  - res_mag = BIG-SML, res_carry=0.
  - res_sign = sign_a if MA>MB; sb_eff if MA<MB; 0 if MA==MB (+0 result).
- res_zero is computed in stage 2 and registered together with the result.
- Latency: exactly 2 clk cycles from input handshake to out_valid, when out_ready is held high.
- Handshake rules:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !flush && (!s1_valid || s2_ready).
  - Input handshake = in_valid && in_ready.
  - Output handshake = out_valid && out_ready.
- Throughput: one result per cycle sustained. With out_ready low, at most 2 results are held and in_ready falls in the cycle the pipeline becomes full.
- Ordering and stability: results leave in input order with no loss or duplication. Outputs hold stable while out_valid && !out_ready.
- Stage advance: s1→s2 transfer occurs when s1_valid && s2_ready. out_valid clears on output handshake if no new s1 data moves in.
- Payload: data registers load only on a transfer. Valid bits alone mark occupancy; stale payload in empty stages is don't-care except after reset.
- flush: on the next edge, s1_valid=0 and out_valid=0.
  - flush has priority over any simultaneous handshake; an in_valid offered in a flush cycle is not accepted.
  - A result presented with out_ready high in the flush cycle counts as consumed.
- Simultaneous events: out handshake, s1→s2 move and new capture can all occur in one cycle; none may be lost.
- Wrap-around: the magnitude sum never wraps; overflow appears only as res_carry=1.
- Inputs are sampled only on the handshake cycle and may change freely otherwise.

Test Plan:
- Add: MANT_W=23, sign_a=0 hid_a=1 frac_a=0x400000 (1.5), sign_b=0 hid_b=1 frac_b=0x200000 (1.25), op=0, out_ready=1 → 2 cycles later out_valid=1, res_carry=1, res_mag=0x600000, res_sign=0, res_zero=0.
- Sub, B larger: A=1.25 (frac 0x200000), B=1.5 (frac 0x400000), both positive, op=1 → res_mag=0x200000, res_carry=0, res_sign=1. Repeat with sign_b=1 and op=0 → identical result.
- Equal cancel: A=B=1.5, op=1 → res_mag=0, res_zero=1, res_sign=0. Separately, -0 + -0 (all magnitude bits 0, both signs 1, op=0) → res_sign=1, res_zero=1.
- Denormal: hid_a=hid_b=0, frac_a=frac_b=0x000001, op=0 → res_mag=0x000002, res_carry=0.
- Backpressure: 4 back-to-back inputs with out_ready=0 → in_ready drops after 2 accepts; release out_ready → results emerge in order, unchanged while stalled, none dropped.
- Flush and reset: pipeline full, assert flush with in_valid=1 → next cycle out_valid=0 and the input is not taken. Pulse rst_n low mid-stream → all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/mantissa_addsub_pipe.sv
// Two-stage sign-magnitude mantissa add/sub between exponent align and normalise/round.
// Stage 1 orders the magnitudes; stage 2 adds or subtracts and registers the result.
module mantissa_addsub_pipe #(
  parameter int unsigned MANT_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_a,
  input  logic              hid_a,
  input  logic [MANT_W-1:0] frac_a,
  input  logic              sign_b,
  input  logic              hid_b,
  input  logic [MANT_W-1:0] frac_b,
  input  logic              op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              res_sign,
  output logic              res_carry,
  output logic [MANT_W:0]   res_mag,
  output logic              res_zero
);

  localparam int unsigned MW = MANT_W + 1;

  logic [MW-1:0] ma, mb;
  logic          eff_sub_in, sb_eff_in, a_ge_b_in;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_eff_sub_q, s1_a_ge_b_q, s1_sign_a_q, s1_sb_eff_q;
  logic [MW-1:0] s1_big_q, s1_sml_q;
  logic          out_valid_q, out_valid_d;

  logic          s2_ready, in_hs, move;

  logic [MW:0]   sum;
  logic [MW-1:0] diff;
  logic          sign_d, carry_d, zero_d;
  logic [MW-1:0] mag_d;

  assign ma         = {hid_a, frac_a};
  assign mb         = {hid_b, frac_b};
  assign sb_eff_in  = sign_b ^ op;
  assign eff_sub_in = sign_a ^ sb_eff_in;
  assign a_ge_b_in  = (ma >= mb);

  // in_ready is held low while reset is asserted, not just after it
  assign s2_ready  = !out_valid_q || out_ready;
  assign in_ready  = rst_n && !flush && (!s1_valid_q || s2_ready);
  assign in_hs     = in_valid && in_ready;
  assign move      = s1_valid_q && s2_ready && !flush;
  assign out_valid = out_valid_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (in_hs)     s1_valid_d = 1'b1;
      else if (move) s1_valid_d = 1'b0;
      if (move)           out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
    end
  end

  always_comb begin
    sum     = {1'b0, s1_big_q} + {1'b0, s1_sml_q};
    diff    = s1_big_q - s1_sml_q;
    sign_d  = s1_sign_a_q;
    carry_d = 1'b0;
    mag_d   = diff;
    if (!s1_eff_sub_q) begin
      carry_d = sum[MW];
      mag_d   = sum[MW-1:0];
      // BIG is the larger magnitude, so BIG==0 means both operands are zero
      if (s1_big_q == '0) sign_d = s1_sign_a_q & s1_sb_eff_q;
    end else if (diff == '0) begin
      sign_d = 1'b0;
    end else if (!s1_a_ge_b_q) begin
      sign_d = s1_sb_eff_q;
    end
    zero_d = (mag_d == '0) && !carry_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_eff_sub_q <= 1'b0;
      s1_a_ge_b_q  <= 1'b0;
      s1_sign_a_q  <= 1'b0;
      s1_sb_eff_q  <= 1'b0;
      s1_big_q     <= '0;
      s1_sml_q     <= '0;
    end else if (in_hs) begin
      s1_eff_sub_q <= eff_sub_in;
      s1_a_ge_b_q  <= a_ge_b_in;
      s1_sign_a_q  <= sign_a;
      s1_sb_eff_q  <= sb_eff_in;
      s1_big_q     <= a_ge_b_in ? ma : mb;
      s1_sml_q     <= a_ge_b_in ? mb : ma;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sign  <= 1'b0;
      res_carry <= 1'b0;
      res_mag   <= '0;
      res_zero  <= 1'b0;
    end else if (move) begin
      res_sign  <= sign_d;
      res_carry <= carry_d;
      res_mag   <= mag_d;
      res_zero  <= zero_d;
    end
  end

endmodule
